// File: rtl/eth_phy_prbs31_ber_ctrl_if.sv
// rtl/eth_phy_prbs31_ber_ctrl_if.sv - management-side control/status bundle for the PRBS31 BER sequencer
interface eth_phy_prbs31_ber_ctrl_if #(
    parameter int WINDOW_WIDTH = 32,
    parameter int ERR_WIDTH    = 32
);
    logic                    start;
    logic                    abort;
    logic [WINDOW_WIDTH-1:0] cfg_window_len;
    logic [ERR_WIDTH-1:0]    cfg_err_threshold;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic                    lock_fail;
    logic                    lock_lost;
    logic [ERR_WIDTH-1:0]    err_total;
    logic [2:0]              state;

    // Register/management side: issues commands, observes results
    modport master (
        output start, abort, cfg_window_len, cfg_err_threshold,
        input  busy, done, pass, lock_fail, lock_lost, err_total, state
    );

    // Sequencer side
    modport slave (
        input  start, abort, cfg_window_len, cfg_err_threshold,
        output busy, done, pass, lock_fail, lock_lost, err_total, state
    );
endinterface

// File: rtl/eth_phy_prbs31_ber_ctrl.sv
// rtl/eth_phy_prbs31_ber_ctrl.sv - PRBS31 bit-error-rate test sequencer for eth_phy_10g (rx_clk domain)
module eth_phy_prbs31_ber_ctrl #(
    parameter int WINDOW_WIDTH  = 32,
    parameter int ERR_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_STABLE   = 64,
    parameter int LOCK_TIMEOUT  = 65536
) (
    input  logic                    rx_clk,
    input  logic                    rx_rst_n,
    eth_phy_prbs31_ber_ctrl_if.slave mgmt,
    input  logic                    rx_block_lock,
    input  logic [6:0]              rx_error_count,
    output logic                    cfg_tx_prbs31_enable,
    output logic                    cfg_rx_prbs31_enable
);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int STB_W = $clog2(LOCK_STABLE + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [SET_W-1:0]     SETTLE_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [STB_W-1:0]     STABLE_LAST  = STB_W'(LOCK_STABLE - 1);
    localparam logic [TO_W-1:0]      TIMEOUT_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX      = {ERR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENABLE  = 3'd1,
        ST_LOCK    = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [SET_W-1:0]        settle_cnt;
    logic [STB_W-1:0]        stable_cnt;
    logic [TO_W-1:0]         timeout_cnt;
    logic [WINDOW_WIDTH-1:0] window_cnt;
    logic [WINDOW_WIDTH-1:0] window_last_q;
    logic [ERR_WIDTH-1:0]    threshold_q;
    logic [ERR_WIDTH-1:0]    err_total_q;
    logic                    lock_fail_q;
    logic                    lock_lost_q;
    logic                    pass_q;
    logic                    done_q;
    logic                    enable_q;

    logic                    accept;
    logic                    abort_run;
    logic                    timeout_hit;
    logic [ERR_WIDTH:0]      err_sum;
    logic [ERR_WIDTH-1:0]    err_acc;
    logic [ERR_WIDTH-1:0]    err_d;
    logic                    lock_fail_d;
    logic                    lock_lost_d;
    logic                    pass_calc;

    // Next-state logic; abort overrides every other transition out of a busy state
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        abort_run   = mgmt.abort && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (mgmt.start && !mgmt.abort) begin
                    state_d = ST_ENABLE;
                    accept  = 1'b1;
                end
            end
            ST_ENABLE: begin
                if (settle_cnt == SETTLE_LAST) state_d = ST_LOCK;
            end
            ST_LOCK: begin
                // Reaching the stable count beats a simultaneous timeout
                if (rx_block_lock && (stable_cnt == STABLE_LAST)) begin
                    state_d = ST_MEASURE;
                end else if (timeout_cnt == TIMEOUT_LAST) begin
                    state_d     = ST_DONE;
                    timeout_hit = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!rx_block_lock || (window_cnt == window_last_q)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_run) begin
            state_d     = ST_IDLE;
            timeout_hit = 1'b0;
        end
    end

    // Saturating accumulation, sticky flags and the verdict the DONE cycle will present
    always_comb begin
        err_sum     = {1'b0, err_total_q} + (ERR_WIDTH + 1)'(rx_error_count);
        err_acc     = err_sum[ERR_WIDTH] ? ERR_MAX : err_sum[ERR_WIDTH-1:0];
        err_d       = err_total_q;
        lock_fail_d = lock_fail_q;
        lock_lost_d = lock_lost_q;
        if (accept) begin
            err_d       = '0;
            lock_fail_d = 1'b0;
            lock_lost_d = 1'b0;
        end else if ((state_q == ST_MEASURE) && !abort_run) begin
            err_d = err_acc;
            if (!rx_block_lock) lock_lost_d = 1'b1;
        end
        if (timeout_hit) lock_fail_d = 1'b1;
        pass_calc = !lock_fail_d && !lock_lost_d && (err_d <= threshold_q);
    end

    // State register
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // Phase counters, latched configuration, results and registered PHY enables
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            settle_cnt    <= '0;
            stable_cnt    <= '0;
            timeout_cnt   <= '0;
            window_cnt    <= '0;
            window_last_q <= '0;
            threshold_q   <= '0;
            err_total_q   <= '0;
            lock_fail_q   <= 1'b0;
            lock_lost_q   <= 1'b0;
            pass_q        <= 1'b0;
            done_q        <= 1'b0;
            enable_q      <= 1'b0;
        end else begin
            settle_cnt  <= (state_q == ST_ENABLE && state_d == ST_ENABLE) ? settle_cnt + SET_W'(1) : '0;
            timeout_cnt <= (state_q == ST_LOCK && state_d == ST_LOCK) ? timeout_cnt + TO_W'(1) : '0;
            stable_cnt  <= (state_q == ST_LOCK && state_d == ST_LOCK && rx_block_lock) ?
                           stable_cnt + STB_W'(1) : '0;
            window_cnt  <= (state_q == ST_MEASURE && state_d == ST_MEASURE) ?
                           window_cnt + WINDOW_WIDTH'(1) : '0;
            if (accept) begin
                // A zero-length window still measures one cycle
                window_last_q <= (mgmt.cfg_window_len == '0) ? '0 : mgmt.cfg_window_len - WINDOW_WIDTH'(1);
                threshold_q   <= mgmt.cfg_err_threshold;
            end
            err_total_q <= err_d;
            lock_fail_q <= lock_fail_d;
            lock_lost_q <= lock_lost_d;
            if (accept || abort_run)                         pass_q <= 1'b0;
            else if (state_d == ST_DONE && state_q != ST_DONE) pass_q <= pass_calc;
            done_q   <= (state_d == ST_DONE);
            enable_q <= (state_d == ST_ENABLE) || (state_d == ST_LOCK) || (state_d == ST_MEASURE);
        end
    end

    assign cfg_tx_prbs31_enable = enable_q;
    assign cfg_rx_prbs31_enable = enable_q;
    assign mgmt.busy      = (state_q != ST_IDLE);
    assign mgmt.done      = done_q;
    assign mgmt.pass      = pass_q;
    assign mgmt.lock_fail = lock_fail_q;
    assign mgmt.lock_lost = lock_lost_q;
    assign mgmt.err_total = err_total_q;
    assign mgmt.state     = state_q;
endmodule
